// File: rtl/kuznechik_apb_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : kuznechik_apb_sequencer
// Purpose  : APB master that drives the Kuznechik APB cipher peripheral as a
//            streaming engine. It takes plaintext blocks on a valid/ready
//            input and runs the peripheral's register protocol: release
//            reset, load DATA_IN, request, poll VALID, read DATA_OUT and
//            acknowledge. Ciphertext leaves on a valid/ready output.
// Ports    : clk_i / rstn_i         clock, asynchronous active-low reset
//            in_valid_i/in_ready_o/in_data_i     plaintext stream
//            out_valid_o/out_ready_i/out_data_o  ciphertext stream
//            err_o/err_code_o/clr_err_i          sticky error (1 PSLVERR,
//                                                2 poll timeout) and clear
//            apb_*                  APB master towards the cipher peripheral
// Options  : KUZ_SEQ_LATENCY_CNT_EN adds lat_cnt_o, the cycle count from the
//            input handshake to out_valid_o of the last completed block.
// Revision : 1.0 - initial release
// ============================================================================
module kuznechik_apb_sequencer #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int APB_DATA_WIDTH = 32,
    parameter int POLL_MAX       = 64
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [127:0]              in_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [127:0]              out_data_o,
    output logic                      err_o,
    output logic [1:0]                err_code_o,
    input  logic                      clr_err_i,
`ifdef KUZ_SEQ_LATENCY_CNT_EN
    output logic [31:0]               lat_cnt_o,
`endif
    output logic [APB_ADDR_WIDTH-1:0] apb_paddr_o,
    output logic [APB_DATA_WIDTH-1:0] apb_pwdata_o,
    output logic                      apb_pwrite_o,
    output logic                      apb_psel_o,
    output logic                      apb_penable_o,
    input  logic [APB_DATA_WIDTH-1:0] apb_prdata_i,
    input  logic                      apb_pready_i,
    input  logic                      apb_pslverr_i
);

    localparam logic [3:0] c_ST_INIT    = 4'd0;
    localparam logic [3:0] c_ST_IDLE    = 4'd1;
    localparam logic [3:0] c_ST_WR_DIN  = 4'd2;
    localparam logic [3:0] c_ST_WR_REQ  = 4'd3;
    localparam logic [3:0] c_ST_POLL    = 4'd4;
    localparam logic [3:0] c_ST_RD_DOUT = 4'd5;
    localparam logic [3:0] c_ST_WR_ACK  = 4'd6;
    localparam logic [3:0] c_ST_OUT     = 4'd7;
    localparam logic [3:0] c_ST_ERROR   = 4'd8;

    localparam logic [7:0] c_ADDR_RST   = 8'h00;
    localparam logic [7:0] c_ADDR_REQ   = 8'h04;
    localparam logic [7:0] c_ADDR_ACK   = 8'h08;
    localparam logic [7:0] c_ADDR_VALID = 8'h0C;
    localparam logic [7:0] c_ADDR_DIN0  = 8'h14;
    localparam logic [7:0] c_ADDR_DOUT0 = 8'h24;

    localparam logic [1:0]  c_ERR_SLV      = 2'd1;
    localparam logic [1:0]  c_ERR_TIMEOUT  = 2'd2;
    localparam logic [15:0] c_POLL_MAX     = 16'(POLL_MAX);
    localparam logic [31:0] c_CTRL_WDATA   = 32'h1;

    // Registered state
    logic [3:0]                r_state;
    logic [1:0]                r_idx;
    logic [15:0]               r_poll_cnt;
    logic [127:0]              r_din;
    logic [127:0]              r_dout;
    logic                      r_out_valid;
    logic                      r_err;
    logic [1:0]                r_err_code;
    logic                      r_psel;
    logic                      r_penable;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic                      r_pwrite;
    logic [APB_DATA_WIDTH-1:0] r_pwdata;

    // Next-state values
    logic [3:0]                w_state;
    logic [1:0]                w_idx;
    logic [15:0]               w_poll_cnt;
    logic [127:0]              w_din;
    logic [127:0]              w_dout;
    logic                      w_out_valid;
    logic                      w_err;
    logic [1:0]                w_err_code;
    logic                      w_psel;
    logic                      w_penable;
    logic [APB_ADDR_WIDTH-1:0] w_paddr;
    logic                      w_pwrite;
    logic [APB_DATA_WIDTH-1:0] w_pwdata;

    // Request to start a new transfer (SETUP) on the next cycle
    logic                      w_issue;
    logic                      w_iss_write;
    logic [7:0]                w_iss_addr;
    logic [31:0]               w_iss_wdata;

    logic                      w_xfer_done;

    assign w_xfer_done = r_psel && r_penable && apb_pready_i;

    always_comb begin
        w_state     = r_state;
        w_idx       = r_idx;
        w_poll_cnt  = r_poll_cnt;
        w_din       = r_din;
        w_dout      = r_dout;
        w_out_valid = r_out_valid;
        w_err       = r_err;
        w_err_code  = r_err_code;
        w_psel      = r_psel;
        w_penable   = r_penable;
        w_paddr     = r_paddr;
        w_pwrite    = r_pwrite;
        w_pwdata    = r_pwdata;
        w_issue     = 1'b0;
        w_iss_write = 1'b0;
        w_iss_addr  = 8'h00;
        w_iss_wdata = 32'h0;

        if (r_psel && !r_penable) begin
            w_penable = 1'b1;
        end else if (w_xfer_done) begin
            // Transfer completes; the follow-up transfer (if any) enters
            // SETUP directly so back-to-back transfers take 2 cycles each.
            w_psel    = 1'b0;
            w_penable = 1'b0;
            if (apb_pslverr_i) begin
                w_state    = c_ST_ERROR;
                w_err      = 1'b1;
                w_err_code = c_ERR_SLV;
            end else begin
                case (r_state)
                    c_ST_INIT: begin
                        w_state = c_ST_IDLE;
                    end
                    c_ST_WR_DIN: begin
                        if (r_idx == 2'd3) begin
                            w_state     = c_ST_WR_REQ;
                            w_issue     = 1'b1;
                            w_iss_write = 1'b1;
                            w_iss_addr  = c_ADDR_REQ;
                            w_iss_wdata = c_CTRL_WDATA;
                        end else begin
                            w_idx       = r_idx + 2'd1;
                            w_issue     = 1'b1;
                            w_iss_write = 1'b1;
                            w_iss_addr  = c_ADDR_DIN0 + {4'd0, w_idx, 2'b00};
                            w_iss_wdata = r_din[{w_idx, 5'b00000} +: 32];
                        end
                    end
                    c_ST_WR_REQ: begin
                        w_state    = c_ST_POLL;
                        w_poll_cnt = 16'd0;
                        w_issue    = 1'b1;
                        w_iss_addr = c_ADDR_VALID;
                    end
                    c_ST_POLL: begin
                        if (apb_prdata_i[0]) begin
                            w_state    = c_ST_RD_DOUT;
                            w_idx      = 2'd0;
                            w_issue    = 1'b1;
                            w_iss_addr = c_ADDR_DOUT0;
                        end else begin
                            w_poll_cnt = r_poll_cnt + 16'd1;
                            if (w_poll_cnt == c_POLL_MAX) begin
                                w_state    = c_ST_ERROR;
                                w_err      = 1'b1;
                                w_err_code = c_ERR_TIMEOUT;
                            end else begin
                                w_issue    = 1'b1;
                                w_iss_addr = c_ADDR_VALID;
                            end
                        end
                    end
                    c_ST_RD_DOUT: begin
                        w_dout[{r_idx, 5'b00000} +: 32] = apb_prdata_i[31:0];
                        if (r_idx == 2'd3) begin
                            w_state     = c_ST_WR_ACK;
                            w_issue     = 1'b1;
                            w_iss_write = 1'b1;
                            w_iss_addr  = c_ADDR_ACK;
                            w_iss_wdata = c_CTRL_WDATA;
                        end else begin
                            w_idx      = r_idx + 2'd1;
                            w_issue    = 1'b1;
                            w_iss_addr = c_ADDR_DOUT0 + {4'd0, w_idx, 2'b00};
                        end
                    end
                    c_ST_WR_ACK: begin
                        w_state     = c_ST_OUT;
                        w_out_valid = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end else if (!r_psel) begin
            // Bus idle: states that begin a transfer or wait on a stream.
            case (r_state)
                c_ST_INIT: begin
                    w_issue     = 1'b1;
                    w_iss_write = 1'b1;
                    w_iss_addr  = c_ADDR_RST;
                    w_iss_wdata = c_CTRL_WDATA;
                end
                c_ST_IDLE: begin
                    if (in_valid_i) begin
                        w_din   = in_data_i;
                        w_state = c_ST_WR_DIN;
                        w_idx   = 2'd0;
                    end
                end
                c_ST_WR_DIN: begin
                    w_issue     = 1'b1;
                    w_iss_write = 1'b1;
                    w_iss_addr  = c_ADDR_DIN0 + {4'd0, r_idx, 2'b00};
                    w_iss_wdata = r_din[{r_idx, 5'b00000} +: 32];
                end
                c_ST_OUT: begin
                    if (out_ready_i) begin
                        w_out_valid = 1'b0;
                        w_state     = c_ST_IDLE;
                    end
                end
                c_ST_ERROR: begin
                    if (clr_err_i) begin
                        w_err      = 1'b0;
                        w_err_code = 2'd0;
                        w_state    = c_ST_INIT;
                    end
                end
                default: begin
                end
            endcase
        end

        if (w_issue) begin
            w_psel    = 1'b1;
            w_penable = 1'b0;
            w_paddr   = APB_ADDR_WIDTH'(w_iss_addr);
            w_pwrite  = w_iss_write;
            w_pwdata  = APB_DATA_WIDTH'(w_iss_wdata);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= c_ST_INIT;
            r_idx       <= 2'd0;
            r_poll_cnt  <= 16'd0;
            r_din       <= 128'd0;
            r_dout      <= 128'd0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 2'd0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
        end else begin
            r_state     <= w_state;
            r_idx       <= w_idx;
            r_poll_cnt  <= w_poll_cnt;
            r_din       <= w_din;
            r_dout      <= w_dout;
            r_out_valid <= w_out_valid;
            r_err       <= w_err;
            r_err_code  <= w_err_code;
            r_psel      <= w_psel;
            r_penable   <= w_penable;
            r_paddr     <= w_paddr;
            r_pwrite    <= w_pwrite;
            r_pwdata    <= w_pwdata;
        end
    end

`ifdef KUZ_SEQ_LATENCY_CNT_EN
    logic [31:0] r_lat_run;
    logic        r_lat_active;
    logic [31:0] r_lat_cnt;
    logic [31:0] w_lat_inc;

    assign w_lat_inc = (r_lat_run == 32'hFFFF_FFFF) ? r_lat_run : r_lat_run + 32'd1;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_lat_run    <= 32'd0;
            r_lat_active <= 1'b0;
            r_lat_cnt    <= 32'd0;
        end else if (r_state == c_ST_IDLE && in_valid_i) begin
            r_lat_run    <= 32'd0;
            r_lat_active <= 1'b1;
        end else if (r_lat_active) begin
            if (w_out_valid && !r_out_valid) begin
                // Count includes the edge on which out_valid_o rises.
                r_lat_cnt    <= w_lat_inc;
                r_lat_active <= 1'b0;
            end else if (w_state == c_ST_ERROR) begin
                r_lat_active <= 1'b0;
            end else begin
                r_lat_run <= w_lat_inc;
            end
        end
    end

    assign lat_cnt_o = r_lat_cnt;
`endif

    assign in_ready_o    = (r_state == c_ST_IDLE);
    assign out_valid_o   = r_out_valid;
    assign out_data_o    = r_dout;
    assign err_o         = r_err;
    assign err_code_o    = r_err_code;
    assign apb_paddr_o   = r_paddr;
    assign apb_pwdata_o  = r_pwdata;
    assign apb_pwrite_o  = r_pwrite;
    assign apb_psel_o    = r_psel;
    assign apb_penable_o = r_penable;

endmodule
`default_nettype wire

// File: tb/tb_kuznechik_apb_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_kuznechik_apb_sequencer
// Purpose  : Self-checking bench for kuznechik_apb_sequencer. A behavioural
//            APB slave stands in for the cipher peripheral (configurable
//            wait states, VALID delay and PSLVERR address); a reference
//            model derives the expected transfer list, ciphertext and
//            latency for every block from plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kuznechik_apb_sequencer;

    localparam int           c_POLL_MAX = 4;
    localparam logic [127:0] c_KAT_PT   = 128'h1122334455667700ffeeddccbbaa9988;
    localparam logic [127:0] c_KAT_CT   = 128'h7f679d90bebc24305a468d42b9d4edcd;

    logic         clk = 1'b0;
    logic         rstn;
    logic         in_valid, in_ready, out_valid, out_ready, err, clr_err;
    logic [127:0] in_data, out_data;
    logic [1:0]   err_code;
    logic [11:0]  paddr;
    logic [31:0]  pwdata, prdata;
    logic         pwrite, psel, penable, pready, pslverr;
`ifdef KUZ_SEQ_LATENCY_CNT_EN
    logic [31:0]  lat_cnt;
`endif

    always #5 clk = ~clk;

    kuznechik_apb_sequencer #(
        .APB_ADDR_WIDTH(12),
        .APB_DATA_WIDTH(32),
        .POLL_MAX      (c_POLL_MAX)
    ) u_dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .err_o        (err),
        .err_code_o   (err_code),
        .clr_err_i    (clr_err),
`ifdef KUZ_SEQ_LATENCY_CNT_EN
        .lat_cnt_o    (lat_cnt),
`endif
        .apb_paddr_o  (paddr),
        .apb_pwdata_o (pwdata),
        .apb_pwrite_o (pwrite),
        .apb_psel_o   (psel),
        .apb_penable_o(penable),
        .apb_prdata_i (prdata),
        .apb_pready_i (pready),
        .apb_pslverr_i(pslverr)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // ------------------------------------------------------------------
    // Behavioural slave / monitor
    // ------------------------------------------------------------------
    int          s_wait        = 0;
    int          s_valid_after = 1;   // 0: VALID never set
    int          s_err_addr    = -1;
    logic [31:0] s_din [4];
    int          s_polls       = 0;
    int          s_wcnt        = 0;
    int          proto_viol    = 0;
    logic [11:0] s_setup_addr;
    logic        s_setup_wr;
    logic [31:0] s_setup_wd;
    logic [127:0] s_ct;

    int          log_addr [$];
    bit          log_wr   [$];
    logic [31:0] log_data [$];

    function automatic logic [127:0] cipher_model(input logic [127:0] pt);
        if (pt == c_KAT_PT) return c_KAT_CT;
        return {pt[63:0], pt[127:64]} ^ 128'h0123456789abcdeffedcba9876543210;
    endfunction

    assign s_ct    = cipher_model({s_din[3], s_din[2], s_din[1], s_din[0]});
    assign pready  = psel && penable && (s_wcnt >= s_wait);
    assign pslverr = pready && (int'(paddr) == s_err_addr);

    always_comb begin
        prdata = 32'h0;
        case (paddr)
            12'h00C: prdata = {31'd0, (s_valid_after != 0) && (s_polls + 1 >= s_valid_after)};
            12'h024: prdata = s_ct[31:0];
            12'h028: prdata = s_ct[63:32];
            12'h02C: prdata = s_ct[95:64];
            12'h030: prdata = s_ct[127:96];
            default: prdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rstn) begin
            s_wcnt <= 0;
        end else begin
            if (penable && !psel) proto_viol <= proto_viol + 1;
            if (psel && !penable) begin
                s_setup_addr <= paddr;
                s_setup_wr   <= pwrite;
                s_setup_wd   <= pwdata;
            end
            if (psel && penable) begin
                if (paddr !== s_setup_addr || pwrite !== s_setup_wr || pwdata !== s_setup_wd)
                    proto_viol <= proto_viol + 1;
                if (pready) begin
                    s_wcnt <= 0;
                    log_addr.push_back(int'(paddr));
                    log_wr.push_back(pwrite);
                    log_data.push_back(pwrite ? pwdata : prdata);
                    if (pwrite && !pslverr) begin
                        case (paddr)
                            12'h004: s_polls <= 0;
                            12'h014: s_din[0] <= pwdata;
                            12'h018: s_din[1] <= pwdata;
                            12'h01C: s_din[2] <= pwdata;
                            12'h020: s_din[3] <= pwdata;
                            default: ;
                        endcase
                    end
                    if (!pwrite && paddr == 12'h00C) s_polls <= s_polls + 1;
                end else begin
                    s_wcnt <= s_wcnt + 1;
                end
            end else begin
                s_wcnt <= 0;
            end
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_wr.delete();
        log_data.delete();
    endtask

    // ------------------------------------------------------------------
    // One block through the sequencer, checked against the model.
    // ------------------------------------------------------------------
    task automatic do_block(input logic [127:0] pt, input int w, input int va,
                            input int hold, input string tag);
        int h, r, exp_lat, bad;
        logic [127:0] exp_ct, held;
        int e_addr [$];
        bit e_wr [$];
        logic [31:0] e_data [$];

        s_wait = w; s_valid_after = va; s_err_addr = -1;
        exp_ct  = cipher_model(pt);
        exp_lat = (2 + w) * (10 + va) + 1;
        for (int k = 0; k < 4; k++) begin
            e_addr.push_back(32'h14 + 4 * k); e_wr.push_back(1'b1); e_data.push_back(pt[32*k +: 32]);
        end
        e_addr.push_back(32'h04); e_wr.push_back(1'b1); e_data.push_back(32'h1);
        for (int k = 0; k < va; k++) begin
            e_addr.push_back(32'h0C); e_wr.push_back(1'b0); e_data.push_back(32'h0);
        end
        for (int k = 0; k < 4; k++) begin
            e_addr.push_back(32'h24 + 4 * k); e_wr.push_back(1'b0); e_data.push_back(32'h0);
        end
        e_addr.push_back(32'h08); e_wr.push_back(1'b1); e_data.push_back(32'h1);

        for (int i = 0; i < 200 && in_ready !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL %s in_ready: got %b want 1", tag, in_ready); return;
        end
        clear_log();
        out_ready = (hold == 0);
        in_data   = pt;
        in_valid  = 1'b1;
        @(negedge clk);
        h        = cyc;
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};

        for (int i = 0; i < 2000 && out_valid !== 1'b1; i++) @(negedge clk);
        r = cyc;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_errors++; $display("FAIL %s out_valid timeout: got %b want 1", tag, out_valid); return;
        end
        n_checks++;
        if (r - h !== exp_lat) begin
            n_errors++; $display("FAIL %s latency: got %0d want %0d", tag, r - h, exp_lat);
        end
        n_checks++;
        if (out_data !== exp_ct) begin
            n_errors++; $display("FAIL %s out_data: got %h want %h", tag, out_data, exp_ct);
        end
`ifdef KUZ_SEQ_LATENCY_CNT_EN
        n_checks++;
        if (lat_cnt !== 32'(exp_lat)) begin
            n_errors++; $display("FAIL %s lat_cnt: got %0d want %0d", tag, lat_cnt, exp_lat);
        end
`endif
        bad = -1;
        for (int k = 0; k < e_addr.size() && k < log_addr.size(); k++)
            if (bad < 0 && (log_addr[k] != e_addr[k] || log_wr[k] != e_wr[k] ||
                            (e_wr[k] && log_data[k] !== e_data[k]))) bad = k;
        n_checks++;
        if (log_addr.size() != e_addr.size() || bad >= 0) begin
            n_errors++;
            $display("FAIL %s transfer list: got %0d transfers (first bad %0d) want %0d",
                     tag, log_addr.size(), bad, e_addr.size());
        end

        held     = out_data;
        in_valid = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL %s hold: got valid=%b ready=%b data=%h want valid=1 ready=0 data=%h",
                         tag, out_valid, in_ready, out_data, held);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || log_addr.size() != e_addr.size()) begin
            n_errors++;
            $display("FAIL %s after handshake: got valid=%b transfers=%0d want valid=0 transfers=%0d",
                     tag, out_valid, log_addr.size(), e_addr.size());
        end
    endtask

    task automatic wait_init_write(input string tag);
        for (int i = 0; i < 20 && log_addr.size() == 0; i++) @(negedge clk);
        n_checks++;
        if (log_addr.size() == 0 || log_addr[0] != 32'h00 || log_wr[0] != 1'b1 || log_data[0] !== 32'h1) begin
            n_errors++;
            $display("FAIL %s first op: got n=%0d addr=%0h wr=%0b data=%0h want write 0x00=0x1", tag,
                     log_addr.size(), (log_addr.size() > 0) ? log_addr[0] : -1,
                     (log_wr.size() > 0) ? log_wr[0] : 1'b0,
                     (log_data.size() > 0) ? log_data[0] : 32'hx);
        end
        for (int i = 0; i < 20 && in_ready !== 1'b1; i++) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        int n;
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, err, err_code, psel, penable, pwrite} !== 8'd0 ||
            paddr !== 12'd0 || pwdata !== 32'd0 || out_data !== 128'd0) begin
            n_errors++;
            $display("FAIL reset outputs: got rdy=%b ov=%b err=%b code=%0d psel=%b pen=%b addr=%h wd=%h od=%h want all 0",
                     in_ready, out_valid, err, err_code, psel, penable, paddr, pwdata, out_data);
        end
`ifdef KUZ_SEQ_LATENCY_CNT_EN
        n_checks++;
        if (lat_cnt !== 32'd0) begin
            n_errors++; $display("FAIL reset lat_cnt: got %0d want 0", lat_cnt);
        end
`endif
        s_wait = 0;
        clear_log();
        rstn = 1'b1;
        wait_init_write("reset");
        n = log_addr.size();
        repeat (10) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || psel !== 1'b0 || log_addr.size() != n) begin
            n_errors++;
            $display("FAIL idle bus: got rdy=%b psel=%b transfers=%0d want rdy=1 psel=0 transfers=%0d",
                     in_ready, psel, log_addr.size(), n);
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || err !== 1'b0 || log_addr.size() != n) begin
            n_errors++;
            $display("FAIL clr_err outside error: got rdy=%b err=%b transfers=%0d want 1 0 %0d",
                     in_ready, err, log_addr.size(), n);
        end
    endtask

    task automatic test_kat();
        do_block(c_KAT_PT, 0, 1 + $urandom_range(0, 1), 0, "kat");
        n_checks++;
        if (out_data !== c_KAT_CT) begin
            n_errors++; $display("FAIL kat ciphertext: got %h want %h", out_data, c_KAT_CT);
        end
    endtask

    task automatic test_latency();
        do_block({$urandom, $urandom, $urandom, $urandom}, 0, 1, 0, "latency23");
    endtask

    task automatic test_wait_states();
        do_block({$urandom, $urandom, $urandom, $urandom}, 3, 2, 5, "wait3");
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++)
            do_block({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 2),
                     $urandom_range(1, c_POLL_MAX), $urandom_range(0, 3), $sformatf("rand%0d", t));
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 3; t++)
            do_block({$urandom, $urandom, $urandom, $urandom}, 0, 1, 0, $sformatf("b2b%0d", t));
    endtask

    task automatic test_poll_timeout();
        int reads, n;
        for (int i = 0; i < 200 && in_ready !== 1'b1; i++) @(negedge clk);
        s_wait = $urandom_range(0, 1); s_valid_after = 0; s_err_addr = -1;
        clear_log();
        in_data = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 500 && err !== 1'b1; i++) @(negedge clk);
        reads = 0;
        foreach (log_addr[k]) if (log_addr[k] == 32'h0C && !log_wr[k]) reads++;
        n_checks++;
        if (err !== 1'b1 || err_code !== 2'd2) begin
            n_errors++; $display("FAIL timeout err: got err=%b code=%0d want 1 2", err, err_code);
        end
        n_checks++;
        if (reads != c_POLL_MAX) begin
            n_errors++; $display("FAIL timeout poll reads: got %0d want %0d", reads, c_POLL_MAX);
        end
        n = log_addr.size();
        repeat (8) @(negedge clk);
        n_checks++;
        if (psel !== 1'b0 || log_addr.size() != n || in_ready !== 1'b0 || out_valid !== 1'b0 || err !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout quiet: got psel=%b transfers=%0d rdy=%b ov=%b err=%b want 0 %0d 0 0 1",
                     psel, log_addr.size(), in_ready, out_valid, err, n);
        end
        clear_log();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        n_checks++;
        if (err !== 1'b0 || err_code !== 2'd0) begin
            n_errors++; $display("FAIL timeout clear: got err=%b code=%0d want 0 0", err, err_code);
        end
        wait_init_write("timeout reinit");
    endtask

    task automatic test_pslverr();
        int n;
        for (int i = 0; i < 200 && in_ready !== 1'b1; i++) @(negedge clk);
        s_wait = 0; s_valid_after = 1; s_err_addr = 32'h1C;
        clear_log();
        in_data = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 100 && err !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || err_code !== 2'd1) begin
            n_errors++; $display("FAIL pslverr err: got err=%b code=%0d want 1 1", err, err_code);
        end
        n = log_addr.size();
        n_checks++;
        if (n != 3 || log_addr[n-1] != 32'h1C) begin
            n_errors++; $display("FAIL pslverr transfers: got %0d want 3 ending at 0x1C", n);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            n_checks++;
            if (in_ready !== 1'b0 || psel !== 1'b0 || log_addr.size() != n) begin
                n_errors++;
                $display("FAIL pslverr quiet: got rdy=%b psel=%b transfers=%0d want 0 0 %0d",
                         in_ready, psel, log_addr.size(), n);
            end
        end
        in_valid = 1'b0;
        s_err_addr = -1;
        clear_log();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        wait_init_write("pslverr reinit");
        n_checks++;
        if (in_ready !== 1'b1 || err !== 1'b0) begin
            n_errors++; $display("FAIL pslverr recover: got rdy=%b err=%b want 1 0", in_ready, err);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 200 && in_ready !== 1'b1; i++) @(negedge clk);
        s_wait = 3; s_valid_after = 1; s_err_addr = -1;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 50 && !(psel === 1'b1 && penable === 1'b1); i++) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if (psel !== 1'b0 || penable !== 1'b0 || in_ready !== 1'b0 || paddr !== 12'd0) begin
            n_errors++;
            $display("FAIL async reset: got psel=%b pen=%b rdy=%b addr=%h want 0 0 0 0",
                     psel, penable, in_ready, paddr);
        end
        @(negedge clk);
        s_wait = 0;
        clear_log();
        rstn = 1'b1;
        wait_init_write("async reinit");
    endtask

    task automatic test_protocol();
        n_checks++;
        if (proto_viol != 0) begin
            n_errors++; $display("FAIL apb protocol: got %0d violations want 0", proto_viol);
        end
    endtask

    initial begin
        test_reset();
        test_kat();
        test_latency();
        test_wait_states();
        test_back_to_back();
        test_poll_timeout();
        test_pslverr();
        test_async_reset();
        test_random();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
